// File: rtl/audio_pkg.sv
// Shared audio framing constants, sample types and ring-buffer address helper
// used by the analysis windower and the synthesis overlap-adder.
package audio_pkg;

    localparam int WIN_LEN  = 4096;
    localparam int HOP      = 1024;
    localparam int RING_LEN = WIN_LEN + HOP;

    typedef logic signed [15:0] sample_t;
    typedef logic        [15:0] coef_t;

    function automatic logic [12:0] ring_next(input logic [12:0] addr);
        return (addr == 13'(RING_LEN - 1)) ? 13'd0 : addr + 13'd1;
    endfunction

endpackage

// File: rtl/win_mac_sat.sv
// Registered signed x unsigned Q0.16 multiply followed by an optional
// saturating accumulate with the previous ring contents.
module win_mac_sat #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     vld_p1,
    input  logic                     acc_en_p1,
    input  logic signed [DATA_W-1:0] samp_p1,
    input  logic        [COEF_W-1:0] coef_p1,
    input  logic signed [DATA_W-1:0] acc_p1,
    output logic                     vld_p2,
    output logic signed [DATA_W-1:0] wr_data_p2
);

    localparam int PW = DATA_W + COEF_W + 1;

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [DATA_W:0] v);
        if (v[DATA_W] != v[DATA_W-1])
            return v[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        return v[DATA_W-1:0];
    endfunction

    logic signed [PW-1:0]     prod_p1;
    logic signed [DATA_W-1:0] p_p1;
    logic                     unused_prod_bits;

    // Dropping the low COEF_W bits of the product is an arithmetic shift that
    // rounds toward -inf; the magnitude always fits back in DATA_W bits.
    assign prod_p1          = PW'(samp_p1) * PW'($signed({1'b0, coef_p1}));
    assign p_p1             = prod_p1[COEF_W +: DATA_W];
    assign unused_prod_bits = ^{prod_p1[PW-1], prod_p1[COEF_W-1:0]};

    // ---- S1 -> S2 boundary ----
    logic signed [DATA_W-1:0] p_p2;
    logic signed [DATA_W-1:0] acc_p2;
    logic                     acc_en_p2;
    logic signed [DATA_W:0]   sum_p2;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p2    <= 1'b0;
            acc_en_p2 <= 1'b0;
            p_p2      <= '0;
            acc_p2    <= '0;
        end else begin
            vld_p2    <= vld_p1;
            acc_en_p2 <= acc_en_p1;
            p_p2      <= p_p1;
            acc_p2    <= acc_p1;
        end
    end

    assign sum_p2     = (DATA_W+1)'(acc_p2) + (DATA_W+1)'(p_p2);
    assign wr_data_p2 = acc_en_p2 ? sat(sum_p2) : p_p2;

endmodule

// File: rtl/hann_overlap_adder.sv
// Windows one post-IFFT frame with the Hann ROM and overlap-adds it into the
// output ring, one sample per cycle, then signals the output reader.
module hann_overlap_adder
    import audio_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        go_in,
    input  logic [12:0] window_start,
    output logic [11:0] ifft_buf_addr,
    input  logic [15:0] ifft_buf_data,
    output logic [11:0] hann_rom_addr,
    input  logic [15:0] hann_rom_data,
    output logic [12:0] ring_rd_addr,
    input  logic [15:0] ring_rd_data,
    output logic [12:0] ring_wr_addr,
    output logic [15:0] ring_wr_data,
    output logic        ring_wren,
    output logic        busy,
    output logic        go_out
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t      state, state_nxt;
    logic [11:0] n_p0;
    logic [12:0] rd_ptr_p0;
    logic        vld_p1, acc_en_p1;
    logic [12:0] wr_addr_p1, wr_addr_p2;
    logic        vld_p2;
    sample_t     wr_data_p2;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // DRAIN holds until both pipeline stages are empty, so DONE means every
    // write of the frame has reached the ring.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (go_in) state_nxt = RUN;
            RUN:   if (n_p0 == 12'(WIN_LEN - 1)) state_nxt = DRAIN;
            DRAIN: if (!vld_p1 && !vld_p2) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---- S0: address issue ----
    always_ff @(posedge clk) begin
        if (reset) begin
            n_p0      <= '0;
            rd_ptr_p0 <= '0;
        end else if (state == IDLE && go_in) begin
            n_p0      <= '0;
            rd_ptr_p0 <= window_start;
        end else if (state == RUN) begin
            n_p0      <= n_p0 + 12'd1;
            rd_ptr_p0 <= ring_next(rd_ptr_p0);
        end
    end

    assign ifft_buf_addr = n_p0;
    assign hann_rom_addr = n_p0;
    assign ring_rd_addr  = rd_ptr_p0;

    // ---- S0 -> S1 boundary: memory read data arrives ----
    // Only the first WIN_LEN-HOP samples overlap earlier frames; the tail
    // positions hold stale data and are overwritten.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1     <= 1'b0;
            acc_en_p1  <= 1'b0;
            wr_addr_p1 <= '0;
        end else begin
            vld_p1     <= (state == RUN);
            acc_en_p1  <= (n_p0 < 12'(WIN_LEN - HOP));
            wr_addr_p1 <= rd_ptr_p0;
        end
    end

    // ---- S1 -> S2 boundary: product/old value registered, write issued ----
    always_ff @(posedge clk) begin
        if (reset) wr_addr_p2 <= '0;
        else       wr_addr_p2 <= wr_addr_p1;
    end

    win_mac_sat #(
        .DATA_W (16),
        .COEF_W (16)
    ) u_mac (
        .clk        (clk),
        .reset      (reset),
        .vld_p1     (vld_p1),
        .acc_en_p1  (acc_en_p1),
        .samp_p1    ($signed(ifft_buf_data)),
        .coef_p1    (hann_rom_data),
        .acc_p1     ($signed(ring_rd_data)),
        .vld_p2     (vld_p2),
        .wr_data_p2 (wr_data_p2)
    );

    assign ring_wr_addr = wr_addr_p2;
    assign ring_wr_data = wr_data_p2;
    assign ring_wren    = vld_p2;
    assign busy         = (state == RUN) || (state == DRAIN);
    assign go_out       = (state == DONE);

endmodule
